rsc2_frame_addr_gen: RTL

//  Input framer for the rsc2 encoder/decoder datapath. Accepts a duobit stream with start-of-packet marks, latches the

---
 rtl/rsc2_frame_addr_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rsc2_frame_addr_gen.sv
// Input framer for the rsc2 datapath: tags each accepted beat with its in-frame pair address,
// flags sop/eop, reports framing errors and drives one registered valid/ready output stage.
module rsc2_frame_addr_gen #(
    parameter int pW     = 13,
    parameter int pDAT_W = 2
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              ival,
    input  logic              isop,
    input  logic [5:0]        iptype,
    input  logic [pDAT_W-1:0] idat,
    input  logic [pW-1:0]     iNm1,
    output logic              oready,
    input  logic              iordy,
    output logic              oval,
    output logic              osop,
    output logic              oeop,
    output logic [pDAT_W-1:0] odat,
    output logic [pW-1:0]     oaddr,
    output logic [5:0]        optype,
    output logic              oerr_sop,
    output logic              oerr_nosop
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [pW-1:0]     r_cnt, w_cnt_nxt;
    logic [pW-1:0]     r_nm1, w_nm1_nxt;

    logic              r_oval, r_osop, r_oeop;
    logic [pDAT_W-1:0] r_odat;
    logic [pW-1:0]     r_oaddr;
    logic [5:0]        r_optype;
    logic              r_err_sop, r_err_nosop;

    logic              w_accept, w_advance;
    logic              w_emit, w_emit_sop, w_emit_eop;
    logic [pW-1:0]     w_emit_addr;
    logic              w_err_sop, w_err_nosop;

    assign oready    = ~r_oval | iordy;
    assign w_accept  = iclkena & ival & oready;
    assign w_advance = iclkena & r_oval & iordy;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_nm1   <= '0;
        end else if (iclkena) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nm1   <= w_nm1_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_nm1_nxt   = r_nm1;
        if (w_accept) begin
            if (isop) begin
                // An isop beat always restarts the frame, whatever state we were in.
                w_nm1_nxt = iNm1;
                if (iNm1 == '0) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = pW'(1);
                end
            end else if (r_state == RUN) begin
                if (r_cnt == r_nm1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + pW'(1);
                end
            end
        end
    end

    always_comb begin
        w_emit      = w_accept & (isop | (r_state == RUN));
        w_emit_sop  = isop;
        w_emit_eop  = isop ? (iNm1 == '0) : (r_cnt == r_nm1);
        w_emit_addr = isop ? '0 : r_cnt;
        w_err_sop   = w_accept & isop & (r_state == RUN);
        w_err_nosop = w_accept & ~isop & (r_state == IDLE);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_oval      <= 1'b0;
            r_osop      <= 1'b0;
            r_oeop      <= 1'b0;
            r_odat      <= '0;
            r_oaddr     <= '0;
            r_optype    <= '0;
            r_err_sop   <= 1'b0;
            r_err_nosop <= 1'b0;
        end else begin
            // Error flags reload every clock so a pulse never outlives one cycle.
            r_err_sop   <= w_err_sop;
            r_err_nosop <= w_err_nosop;
            if (w_emit) begin
                r_oval  <= 1'b1;
                r_osop  <= w_emit_sop;
                r_oeop  <= w_emit_eop;
                r_odat  <= idat;
                r_oaddr <= w_emit_addr;
                if (isop)
                    r_optype <= iptype;
            end else if (w_advance) begin
                r_oval <= 1'b0;
            end
        end
    end

    assign oval       = r_oval;
    assign osop       = r_osop;
    assign oeop       = r_oeop;
    assign odat       = r_odat;
    assign oaddr      = r_oaddr;
    assign optype     = r_optype;
    assign oerr_sop   = r_err_sop;
    assign oerr_nosop = r_err_nosop;

endmodule
